// File: rtl/sum1b_chk_pkg.sv
// Shared types and constants for the sum1b_chk 1-bit full-adder checker.
package sum1b_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_COVERED = 2'd2,
        ST_FAILED  = 2'd3
    } state_t;

    localparam logic [7:0] COV_ALL = 8'hFF;

endpackage

// File: rtl/sum1b_ref.sv
// Golden combinational model of a 1-bit full adder.
module sum1b_ref (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s_exp,
    output logic co_exp
);

    assign s_exp  = a ^ b ^ ci;
    assign co_exp = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sum1b_chk.sv
// Online checker for a 1-bit full adder: mismatch counting, input coverage and pass/fail FSM.
// Define SUM1B_CHK_CAPTURE_EN to latch the first failing vector and its index.
module sum1b_chk
    import sum1b_chk_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int VEC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             ci,
    input  logic             s,
    input  logic             co,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] vec_cnt,
    output logic [7:0]       cov,
    output logic             cov_done,
    output logic             pass,
    output logic [4:0]       fail_vec,
    output logic [VEC_W-1:0] fail_idx
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [VEC_W-1:0] r_vec_cnt;
    logic [7:0]       r_cov;
    logic             r_cov_done;
    logic             r_pass;
    logic             w_s_exp;
    logic             w_co_exp;
    logic             w_mis;
    logic [2:0]       w_idx;
    logic [7:0]       w_cov_nxt;

    sum1b_ref u_ref (
        .a      (a),
        .b      (b),
        .ci     (ci),
        .s_exp  (w_s_exp),
        .co_exp (w_co_exp)
    );

    assign w_idx = {a, b, ci};
    assign w_mis = en & ((s != w_s_exp) | (co != w_co_exp));

    always_comb begin
        w_cov_nxt = r_cov;
        if (en)
            w_cov_nxt[w_idx] = 1'b1;
    end

    // IDLE shares CHECK's transitions so a bad or completing first vector is not lost.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_CHECK: begin
                    if (en) begin
                        if (w_mis)
                            w_state_nxt = ST_FAILED;
                        else if ((w_cov_nxt == COV_ALL) && !r_err)
                            w_state_nxt = ST_COVERED;
                        else
                            w_state_nxt = ST_CHECK;
                    end
                end
                ST_COVERED: if (w_mis) w_state_nxt = ST_FAILED;
                ST_FAILED:  w_state_nxt = ST_FAILED;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_vec_cnt  <= '0;
            r_cov      <= '0;
            r_cov_done <= 1'b0;
            r_pass     <= 1'b0;
        end else if (clr) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_vec_cnt  <= '0;
            r_cov      <= '0;
            r_cov_done <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_cov      <= w_cov_nxt;
            r_cov_done <= (w_cov_nxt == COV_ALL);
            r_pass     <= (w_state_nxt == ST_COVERED);
            if (en && (r_vec_cnt != {VEC_W{1'b1}}))
                r_vec_cnt <= r_vec_cnt + VEC_W'(1);
            if (w_mis) begin
                r_err <= 1'b1;
                if (r_err_cnt != {ERR_W{1'b1}})
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign vec_cnt  = r_vec_cnt;
    assign cov      = r_cov;
    assign cov_done = r_cov_done;
    assign pass     = r_pass;

`ifdef SUM1B_CHK_CAPTURE_EN
    logic [4:0]       r_fail_vec;
    logic [VEC_W-1:0] r_fail_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_vec <= '0;
            r_fail_idx <= '0;
        end else if (clr) begin
            r_fail_vec <= '0;
            r_fail_idx <= '0;
        end else if (w_mis && !r_err) begin
            r_fail_vec <= {a, b, ci, s, co};
            r_fail_idx <= r_vec_cnt;
        end
    end

    assign fail_vec = r_fail_vec;
    assign fail_idx = r_fail_idx;
`else
    assign fail_vec = '0;
    assign fail_idx = '0;
`endif

endmodule

// File: tb/tb_sum1b_chk.sv
// Scoreboard bench for sum1b_chk: directed scenarios plus random traffic against an arithmetic model.
module tb_sum1b_chk;

    localparam int EW = 4;
    localparam int VW = 6;
    localparam int EMAX = (1 << EW) - 1;
    localparam int VMAX = (1 << VW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, en, clr, a, b, ci, s, co;
    logic          err, cov_done, pass;
    logic [EW-1:0] err_cnt;
    logic [VW-1:0] vec_cnt, fail_idx;
    logic [7:0]    cov;
    logic [4:0]    fail_vec;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          err;
        logic [EW-1:0] err_cnt;
        logic [VW-1:0] vec_cnt;
        logic [7:0]    cov;
        logic          cov_done;
        logic          pass;
        logic [4:0]    fail_vec;
        logic [VW-1:0] fail_idx;
    } exp_t;

    exp_t q[$];

    // reference model state
    bit         seen[8];
    int         m_vecs, m_errs;
    bit         m_err;
    logic [4:0] m_fvec;
    int         m_fidx;

    sum1b_chk #(.ERR_W(EW), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .a(a), .b(b), .ci(ci), .s(s), .co(co),
        .err(err), .err_cnt(err_cnt), .vec_cnt(vec_cnt), .cov(cov),
        .cov_done(cov_done), .pass(pass), .fail_vec(fail_vec), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        m_vecs = 0;
        m_errs = 0;
        m_err  = 1'b0;
        m_fvec = '0;
        m_fidx = 0;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        bit   all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e.cov[i] = seen[i];
            if (!seen[i]) all = 1'b0;
        end
        e.err      = m_err;
        e.err_cnt  = EW'((m_errs > EMAX) ? EMAX : m_errs);
        e.vec_cnt  = VW'((m_vecs > VMAX) ? VMAX : m_vecs);
        e.cov_done = all;
        e.pass     = all && !m_err;
`ifdef SUM1B_CHK_CAPTURE_EN
        e.fail_vec = m_fvec;
        e.fail_idx = VW'(m_fidx);
`else
        e.fail_vec = '0;
        e.fail_idx = '0;
`endif
        return e;
    endfunction

    function automatic void m_step(bit e_i, bit c_i, bit a_i, bit b_i, bit ci_i, bit s_i, bit co_i);
        int tot;
        bit mis;
        if (c_i) begin
            m_clear();
        end else if (e_i) begin
            tot = int'(a_i) + int'(b_i) + int'(ci_i);
            mis = (int'(s_i) != (tot % 2)) || (co_i != (tot >= 2));
            if (mis && !m_err) begin
                m_fvec = {a_i, b_i, ci_i, s_i, co_i};
                m_fidx = (m_vecs > VMAX) ? VMAX : m_vecs;
            end
            m_vecs++;
            if (mis) begin
                m_errs++;
                m_err = 1'b1;
            end
            seen[int'(a_i) * 4 + int'(b_i) * 2 + int'(ci_i)] = 1'b1;
        end
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit e_i, bit c_i, bit a_i, bit b_i, bit ci_i, bit s_i, bit co_i);
        @(negedge clk);
        en = e_i; clr = c_i; a = a_i; b = b_i; ci = ci_i; s = s_i; co = co_i;
        m_step(e_i, c_i, a_i, b_i, ci_i, s_i, co_i);
        q.push_back(m_expect());
    endtask

    task automatic vec(bit [2:0] abc, bit sflip, bit coflip);
        int tot;
        tot = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
        drive(1'b1, 1'b0, abc[2], abc[1], abc[0],
              bit'(tot % 2) ^ sflip, bit'(tot >= 2) ^ coflip);
    endtask

    task automatic clear();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(string tag);
        cmp({tag, "_err"}, 32'(err), 0);
        cmp({tag, "_err_cnt"}, 32'(err_cnt), 0);
        cmp({tag, "_vec_cnt"}, 32'(vec_cnt), 0);
        cmp({tag, "_cov"}, 32'(cov), 0);
        cmp({tag, "_cov_done"}, 32'(cov_done), 0);
        cmp({tag, "_pass"}, 32'(pass), 0);
        cmp({tag, "_fail_vec"}, 32'(fail_vec), 0);
        cmp({tag, "_fail_idx"}, 32'(fail_idx), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        m_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: one expected snapshot per driven cycle, checked just after the sampling edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("sb_err", 32'(err), 32'(e.err));
                cmp("sb_err_cnt", 32'(err_cnt), 32'(e.err_cnt));
                cmp("sb_vec_cnt", 32'(vec_cnt), 32'(e.vec_cnt));
                cmp("sb_cov", 32'(cov), 32'(e.cov));
                cmp("sb_cov_done", 32'(cov_done), 32'(e.cov_done));
                cmp("sb_pass", 32'(pass), 32'(e.pass));
                cmp("sb_fail_vec", 32'(fail_vec), 32'(e.fail_vec));
                cmp("sb_fail_idx", 32'(fail_idx), 32'(e.fail_idx));
            end
        end
    end

    initial begin
        bit e_r, c_r;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        a = 1'b0; b = 1'b0; ci = 1'b0; s = 1'b0; co = 1'b0;
        m_clear();
        #1;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // full correct coverage
        for (int i = 0; i < 8; i++) vec(3'(i), 1'b0, 1'b0);
        settle();
        cmp("cover_vec_cnt", 32'(vec_cnt), 8);
        cmp("cover_err_cnt", 32'(err_cnt), 0);
        cmp("cover_cov", 32'(cov), 32'hFF);
        cmp("cover_done", 32'(cov_done), 1);
        cmp("cover_pass", 32'(pass), 1);

        // first failure after three good vectors
        clear();
        for (int i = 0; i < 3; i++) vec(3'(i), 1'b0, 1'b0);
        vec(3'b110, 1'b1, 1'b0);
        settle();
        cmp("fail_err", 32'(err), 1);
        cmp("fail_err_cnt", 32'(err_cnt), 1);
        cmp("fail_pass", 32'(pass), 0);
`ifdef SUM1B_CHK_CAPTURE_EN
        cmp("fail_vec_cap", 32'(fail_vec), 32'b11011);
        cmp("fail_idx_cap", 32'(fail_idx), 3);
`else
        cmp("fail_vec_off", 32'(fail_vec), 0);
        cmp("fail_idx_off", 32'(fail_idx), 0);
`endif

        // error counter saturation
        clear();
        for (int i = 0; i < 20; i++) vec(3'b000, 1'b1, 1'b0);
        settle();
        cmp("sat_err_cnt", 32'(err_cnt), 15);
        cmp("sat_cov", 32'(cov), 32'h01);
        cmp("sat_pass", 32'(pass), 0);

        // clear wins over a mismatching sample
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk_zero("clr_en");

        // asynchronous reset mid-run
        for (int i = 0; i < 5; i++) vec(3'(i), 1'b0, 1'b0);
        do_reset();
        vec(3'b101, 1'b0, 1'b0);
        settle();
        cmp("post_rst_vec_cnt", 32'(vec_cnt), 1);

        // coverage completed by a failing vector
        clear();
        for (int i = 0; i < 7; i++) vec(3'(i), 1'b0, 1'b0);
        vec(3'b111, 1'b0, 1'b1);
        settle();
        cmp("last_fail_done", 32'(cov_done), 1);
        cmp("last_fail_pass", 32'(pass), 0);
        cmp("last_fail_err", 32'(err), 1);

        // vector counter saturation
        clear();
        for (int i = 0; i < 70; i++) vec(3'($urandom_range(0, 7)), 1'b0, 1'b0);
        settle();
        cmp("vec_sat", 32'(vec_cnt), VMAX);

        // random traffic
        clear();
        for (int i = 0; i < 400; i++) begin
            e_r = ($urandom_range(0, 9) < 7);
            c_r = ($urandom_range(0, 99) < 2);
            if (e_r && !c_r) begin
                vec(3'($urandom_range(0, 7)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
            end else begin
                drive(e_r, c_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum1b_chk.md
SUM1B_CHK -- requirements
Module: sum1b_chk

Interface
REQ-001 Parameter ERR_W, default 8, width of saturating error counter.
REQ-002 Parameter VEC_W, default 16, width of saturating checked-vector counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  sample strobe, check a/b/ci/s/co this cycle.
REQ-006 clr  input  1  synchronous clear of all checker state.
REQ-007 a, b, ci  input  1 each  operands applied to the 1-bit adder under observation.
REQ-008 s, co  input  1 each  sum and carry observed from the adder.
REQ-009 err  output  1  sticky mismatch flag.
REQ-010 err_cnt  output  ERR_W  mismatches seen.
REQ-011 vec_cnt  output  VEC_W  vectors checked.
REQ-012 cov  output  8  coverage bitmap, bit index {a,b,ci}.
REQ-013 cov_done  output  1  all 8 input combinations seen.
REQ-014 pass  output  1  cov_done and not err.
REQ-015 fail_vec  output  5  first failing {a,b,ci,s,co}.
REQ-016 fail_idx  output  VEC_W  vec_cnt value at first failure.

Function
REQ-017 Expected values SHALL be s_exp = a^b^ci, co_exp = majority(a,b,ci).
REQ-018 Mismatch SHALL be (s!=s_exp)|(co!=co_exp), evaluated only when en=1.
REQ-019 All outputs SHALL be registered; effect of a sampled vector SHALL appear 1 cycle after the en edge.
REQ-020 FSM states SHALL be IDLE, CHECK, COVERED, FAILED.
REQ-021 IDLE->CHECK on first en; CHECK->COVERED when cov becomes 8'hFF with no error so far; CHECK or COVERED->FAILED on any mismatch; FAILED is terminal until clr/reset.
REQ-022 In COVERED and FAILED, sampling SHALL continue: counters and cov keep updating.
REQ-023 vec_cnt SHALL increment per en and saturate at all-ones; err_cnt SHALL increment per mismatch and saturate at all-ones.
REQ-024 cov bit {a,b,ci} SHALL set on each en, matching or not; bits never clear except by clr/reset.
REQ-025 cov_done SHALL equal (cov==8'hFF) registered; pass SHALL be 1 only in state COVERED.
REQ-026 err SHALL set on the first mismatch and remain set.
REQ-027 clr SHALL override en in the same cycle: state IDLE, all outputs to reset values, vector ignored.
REQ-028 When both mismatch and coverage completion occur on the same vector, the next state SHALL be FAILED.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, err=0, err_cnt=0, vec_cnt=0, cov=0, cov_done=0, pass=0, fail_vec=0, fail_idx=0.
REQ-030 Reset asserted mid-run SHALL discard all history; the first en after release is vector 0.

Configuration
REQ-031 Macro SUM1B_CHK_CAPTURE_EN, when defined, SHALL enable first-failure capture: on the first mismatch fail_vec latches {a,b,ci,s,co} and fail_idx latches the pre-increment vec_cnt; later mismatches do not update them.
REQ-032 Without SUM1B_CHK_CAPTURE_EN, fail_vec and fail_idx SHALL remain present and be driven constant 0; no capture registers.

Structure
REQ-033 Shared package sum1b_chk_pkg SHALL hold the FSM state enum and the COV_ALL=8'hFF constant.
REQ-034 Golden model SHALL be sub-module sum1b_ref (combinational a,b,ci -> s_exp,co_exp), instanced once.

Verification
REQ-035 Reset, then all 8 {a,b,ci} combos with correct s/co, en=1 each -> vec_cnt=8, err_cnt=0, cov=FF, cov_done=1, pass=1, state COVERED.
REQ-036 After 3 correct vectors, a=1,b=1,ci=0 with s=1,co=1 -> err=1, err_cnt=1, state FAILED; with CAPTURE_EN fail_vec=5'b11011, fail_idx=3, else both 0.
REQ-037 Repeat vector {0,0,0} 20 times with ERR_W=4 and wrong s each time -> err_cnt saturates at 15, cov=8'h01, pass=0.
REQ-038 clr and en both high on a mismatching vector -> next cycle all outputs 0, state IDLE.
REQ-039 rst_n pulsed low mid-run after 5 vectors -> outputs 0 asynchronously, before next clk edge; next en counts as vec_cnt=1.
REQ-040 Final missing combination applied with wrong co -> state FAILED, cov_done=1, pass=0.
